// File: rtl/sdram_uart_monitor_pkg.sv
// Shared constants and FSM encoding for the UART-to-SDRAM debug monitor.
// Latency: none (definitions only).
// Backpressure: n/a.
package sdram_uart_monitor_pkg;

  // Command bytes
  localparam logic [7:0] CH_AT    = 8'h40; // '@' load address
  localparam logic [7:0] CH_L     = 8'h6c; // 'l' load length
  localparam logic [7:0] CH_X     = 8'h78; // 'x' clear address
  localparam logic [7:0] CH_W     = 8'h77; // 'w' single write
  localparam logic [7:0] CH_R     = 8'h72; // 'r' burst read
  localparam logic [7:0] CH_DOT   = 8'h2e; // '.' next word
  localparam logic [7:0] CH_F     = 8'h66; // 'f' fill (also hex digit)
  localparam logic [7:0] CH_Q     = 8'h71; // 'q' abort
  localparam logic [7:0] CH_CR    = 8'h0d;
  localparam logic [7:0] CH_LF    = 8'h0a;
  localparam logic [7:0] CH_BANG  = 8'h21;
  localparam logic [7:0] CH_QMARK = 8'h3f;

  // Hex digit ranges
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_A_LO = 8'h61;
  localparam logic [7:0] CH_F_LO = 8'h66;
  localparam logic [7:0] CH_A_UP = 8'h41;
  localparam logic [7:0] CH_F_UP = 8'h46;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_TX_WORD,
    ST_WR_ISSUE,
    ST_FILL_ISSUE,
    ST_TX_EOL,
    ST_TX_ACK
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sdram_uart_monitor_hex_nibble.sv
// Nibble <-> ASCII hex conversion (lowercase out, either case in).
// Latency: purely combinational.
// Backpressure: n/a.
module hex_nibble
  import sdram_uart_monitor_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [7:0] ascii_o,
  input  logic [7:0] ch_i,
  output logic       is_hex_o,
  output logic [3:0] nib_o
);

  // Encode a nibble as a lowercase hex character
  always_comb begin
    if (val_i < 4'd10) ascii_o = CH_0 + {4'h0, val_i};
    else               ascii_o = CH_A_LO - 8'd10 + {4'h0, val_i};
  end

  // Decode an ASCII hex character; letters carry their value in the low nibble minus 9
  always_comb begin
    is_hex_o = 1'b0;
    nib_o    = 4'h0;
    if (ch_i >= CH_0 && ch_i <= CH_9) begin
      is_hex_o = 1'b1;
      nib_o    = ch_i[3:0];
    end else if ((ch_i >= CH_A_LO && ch_i <= CH_F_LO) ||
                 (ch_i >= CH_A_UP && ch_i <= CH_F_UP)) begin
      is_hex_o = 1'b1;
      nib_o    = ch_i[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/sdram_uart_monitor.sv
// UART command interpreter driving the SDRAM logical port: read/hex dump, write, fill, abort.
// Latency: 'w' to sd_wr_enable 1 cycle when idle bus; echo appears 1 cycle after the rx byte.
// Backpressure: FSM output characters wait on tx_ready; echo/'?' dropped when tx_ready=0; requests wait on sd_busy.
module sdram_uart_monitor
  import sdram_uart_monitor_pkg::*;
#(
  parameter int ADDR_BITS = 25,
  parameter int DATA_BITS = 8,
  parameter int LEN_BITS  = 16,
  parameter int HEX_OUT   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_strobe,
  output logic [7:0]           tx_data,
  output logic                 tx_strobe,
  input  logic                 tx_ready,
  output logic [ADDR_BITS-1:0] sd_wr_addr,
  output logic [DATA_BITS-1:0] sd_wr_data,
  output logic                 sd_wr_enable,
  output logic [ADDR_BITS-1:0] sd_rd_addr,
  output logic                 sd_rd_enable,
  input  logic [DATA_BITS-1:0] sd_rd_data,
  input  logic                 sd_rd_ready,
  input  logic                 sd_busy,
  output logic                 active
);

  localparam int         ACC_W    = max3(ADDR_BITS, LEN_BITS, DATA_BITS);
  localparam int         NIBS     = DATA_BITS / 4;
  localparam logic [3:0] LAST_IDX = (HEX_OUT != 0) ? 4'(NIBS - 1) : 4'd0;

  state_e               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [LEN_BITS-1:0]  rem_q, rem_d;
  logic [DATA_BITS-1:0] word_q, word_d;
  logic [3:0]           idx_q, idx_d;      // nibble index in TX_WORD, CR/LF index in TX_EOL
  logic                 abort_q, abort_d;
  logic                 digits_q, digits_d; // a hex number is being typed
  logic                 echo_vld_q, echo_vld_d;
  logic [7:0]           echo_dat_q, echo_dat_d;

  logic                 fsm_tx_vld;
  logic [7:0]           fsm_tx_dat;
  logic                 rx_hex;
  logic [3:0]           rx_nib;
  logic [3:0]           tx_nib;
  logic [7:0]           tx_hex_char;
  logic [5:0]           shamt;
  logic                 q_now;

  assign shamt  = {4'(NIBS - 1) - idx_q, 2'b00};
  assign tx_nib = 4'(word_q >> shamt);

  hex_nibble u_hex (
    .val_i   (tx_nib),
    .ascii_o (tx_hex_char),
    .ch_i    (rx_data),
    .is_hex_o(rx_hex),
    .nib_o   (rx_nib)
  );

  assign q_now      = rx_strobe && (rx_data == CH_Q);
  assign active     = (state_q != ST_IDLE);
  assign sd_wr_addr = addr_q;
  assign sd_rd_addr = addr_q;
  // Fill writes the low address bits as data; single writes take the accumulator
  assign sd_wr_data = (state_q == ST_FILL_ISSUE) ? DATA_BITS'(addr_q) : acc_q[DATA_BITS-1:0];
  // Echo owns the tx port only while idle; otherwise the FSM character does
  assign tx_strobe  = tx_ready && ((state_q == ST_IDLE) ? echo_vld_q : fsm_tx_vld);
  assign tx_data    = (state_q == ST_IDLE) ? echo_dat_q : fsm_tx_dat;

  // Next-state, command decode and request/character generation
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    addr_d       = addr_q;
    len_d        = len_q;
    rem_d        = rem_q;
    word_d       = word_q;
    idx_d        = idx_q;
    abort_d      = abort_q;
    digits_d     = digits_q;
    echo_vld_d   = 1'b0;
    echo_dat_d   = 8'h00;
    fsm_tx_vld   = 1'b0;
    fsm_tx_dat   = 8'h00;
    sd_rd_enable = 1'b0;
    sd_wr_enable = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idx_d = 4'd0;
        if (rx_strobe) begin
          // 'f' is a digit only while a number is being typed; start such numbers with '0'
          if (rx_hex && (digits_q || rx_data != CH_F)) begin
            acc_d      = {acc_q[ACC_W-5:0], rx_nib};
            digits_d   = 1'b1;
            echo_vld_d = 1'b1;
            echo_dat_d = rx_data;
          end else begin
            digits_d = 1'b0;
            case (rx_data)
              CH_AT:  begin addr_d = acc_q[ADDR_BITS-1:0]; acc_d = '0; end
              CH_L:   begin len_d = acc_q[LEN_BITS-1:0]; acc_d = '0; end
              CH_X:   begin addr_d = '0; acc_d = '0; end
              CH_W:   state_d = ST_WR_ISSUE;
              CH_R:   begin
                rem_d   = len_q;
                state_d = (len_q == '0) ? ST_TX_EOL : ST_RD_ISSUE;
              end
              CH_DOT: begin
                addr_d  = addr_q + ADDR_BITS'(1);
                rem_d   = LEN_BITS'(1);
                state_d = ST_RD_ISSUE;
              end
              CH_F:   begin
                rem_d   = len_q;
                state_d = (len_q == '0) ? ST_TX_ACK : ST_FILL_ISSUE;
              end
              CH_CR, CH_LF: ;
              default: begin
                echo_vld_d = 1'b1;
                echo_dat_d = CH_QMARK;
              end
            endcase
          end
        end
      end

      ST_RD_ISSUE: begin
        if (abort_q) begin
          state_d = ST_TX_EOL;
        end else if (!sd_busy) begin
          sd_rd_enable = 1'b1;
          state_d      = ST_RD_WAIT;
        end
      end

      // An abort never cuts a read short; the word in flight is still captured
      ST_RD_WAIT: begin
        if (sd_rd_ready) begin
          word_d  = sd_rd_data;
          idx_d   = 4'd0;
          state_d = ST_TX_WORD;
        end
      end

      ST_TX_WORD: begin
        fsm_tx_vld = 1'b1;
        fsm_tx_dat = (HEX_OUT != 0) ? tx_hex_char : 8'(word_q);
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            addr_d  = addr_q + ADDR_BITS'(1);
            rem_d   = rem_q - LEN_BITS'(1);
            idx_d   = 4'd0;
            state_d = (rem_q == LEN_BITS'(1) || abort_q || q_now) ? ST_TX_EOL : ST_RD_ISSUE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      ST_WR_ISSUE: begin
        if (!sd_busy) begin
          sd_wr_enable = 1'b1;
          addr_d       = addr_q + ADDR_BITS'(1);
          acc_d        = '0;
          state_d      = ST_TX_ACK;
        end
      end

      ST_FILL_ISSUE: begin
        if (abort_q) begin
          state_d = ST_TX_EOL;
        end else if (!sd_busy) begin
          sd_wr_enable = 1'b1;
          addr_d       = addr_q + ADDR_BITS'(1);
          rem_d        = rem_q - LEN_BITS'(1);
          if (rem_q == LEN_BITS'(1)) state_d = ST_TX_ACK;
        end
      end

      ST_TX_EOL: begin
        fsm_tx_vld = 1'b1;
        fsm_tx_dat = (idx_q == 4'd0) ? CH_CR : CH_LF;
        if (tx_ready) begin
          if (idx_q == 4'd0) begin
            idx_d = 4'd1;
          end else begin
            idx_d   = 4'd0;
            state_d = ST_IDLE;
          end
        end
      end

      ST_TX_ACK: begin
        fsm_tx_vld = 1'b1;
        fsm_tx_dat = CH_BANG;
        if (tx_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && q_now) abort_d = 1'b1;
    if (state_d == ST_IDLE)           abort_d = 1'b0;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      addr_q     <= '0;
      len_q      <= LEN_BITS'(1);
      rem_q      <= '0;
      word_q     <= '0;
      idx_q      <= 4'd0;
      abort_q    <= 1'b0;
      digits_q   <= 1'b0;
      echo_vld_q <= 1'b0;
      echo_dat_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      abort_q    <= abort_d;
      digits_q   <= digits_d;
      echo_vld_q <= echo_vld_d;
      echo_dat_q <= echo_dat_d;
    end
  end

endmodule

// File: tb/tb_sdram_uart_monitor.sv
// Scoreboard bench for sdram_uart_monitor: directed command strings, SDRAM model, tx/wr/rd queues.
// Latency: read data returned 3 cycles after each read request.
// Backpressure: sd_busy toggled during fill, tx_ready held low mid-dump.
module tb_sdram_uart_monitor;

  localparam int AB = 25;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_strobe;
  logic [7:0]    tx_data;
  logic          tx_strobe;
  logic          tx_ready;
  logic [AB-1:0] sd_wr_addr;
  logic [DB-1:0] sd_wr_data;
  logic          sd_wr_enable;
  logic [AB-1:0] sd_rd_addr;
  logic          sd_rd_enable;
  logic [DB-1:0] sd_rd_data;
  logic          sd_rd_ready;
  logic          sd_busy = 1'b0;
  logic          active;

  sdram_uart_monitor #(.ADDR_BITS(AB), .DATA_BITS(DB), .LEN_BITS(16), .HEX_OUT(1)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .tx_data(tx_data), .tx_strobe(tx_strobe), .tx_ready(tx_ready),
    .sd_wr_addr(sd_wr_addr), .sd_wr_data(sd_wr_data), .sd_wr_enable(sd_wr_enable),
    .sd_rd_addr(sd_rd_addr), .sd_rd_enable(sd_rd_enable), .sd_rd_data(sd_rd_data),
    .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy), .active(active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int rd_seen = 0;
  int wr_seen = 0;
  int tx_seen = 0;
  int busy_mode = 0;

  logic [7:0]       exp_tx[$];
  logic [AB-1:0]    exp_rd[$];
  logic [AB+DB-1:0] exp_wr[$];
  logic [AB-1:0]    rd_req_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  function automatic void exp_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
  endfunction

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(posedge clk); #1;
      rx_data   = s[i];
      rx_strobe = 1'b1;
      @(posedge clk); #1;
      rx_strobe = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((exp_tx.size() != 0 || exp_rd.size() != 0 || exp_wr.size() != 0 || active) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drain_in_time"}, (t < 3000), 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_rd(input string name, input int target);
    int t = 0;
    while (rd_seen < target && t < 500) begin
      @(posedge clk);
      t++;
    end
    check({name, "_read_seen_in_time"}, (t < 500), 1'b1);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ctl"}, {tx_strobe, tx_data, sd_wr_enable, sd_rd_enable, sd_wr_data, active}, 64'h0);
    check({name, "_addr"}, {sd_wr_addr, sd_rd_addr}, 64'h0);
  endtask

  // Busy pattern: constantly free, or alternating every cycle
  initial forever begin
    @(posedge clk); #1;
    sd_busy = (busy_mode != 0) ? ~sd_busy : 1'b0;
  end

  // SDRAM read model: data = low address byte + 0xDC, returned 3 cycles after the request
  initial begin : rd_model
    logic [AB-1:0] a;
    sd_rd_ready = 1'b0;
    sd_rd_data  = '0;
    forever begin
      @(posedge clk); #1;
      sd_rd_ready = 1'b0;
      if (rd_req_q.size() != 0) begin
        a = rd_req_q.pop_front();
        repeat (2) @(posedge clk);
        #1;
        sd_rd_data  = a[7:0] + 8'hdc;
        sd_rd_ready = 1'b1;
      end
    end
  end

  // Output monitor: pops the scoreboard whenever the DUT presents a byte or request
  always @(negedge clk) begin
    if (!reset) begin
      if (sd_rd_enable || sd_wr_enable) begin
        check("req_while_not_busy", sd_busy, 1'b0);
        check("req_exclusive", sd_rd_enable & sd_wr_enable, 1'b0);
      end
      if (tx_strobe) begin
        tx_seen++;
        check("tx_only_when_ready", tx_ready, 1'b1);
        if (exp_tx.size() == 0) unexpected("tx_byte", tx_data);
        else check("tx_byte", tx_data, exp_tx.pop_front());
      end
      if (sd_wr_enable) begin
        wr_seen++;
        if (exp_wr.size() == 0) unexpected("sd_write", {sd_wr_addr, sd_wr_data});
        else check("sd_write_addr_data", {sd_wr_addr, sd_wr_data}, exp_wr.pop_front());
      end
      if (sd_rd_enable) begin
        rd_seen++;
        rd_req_q.push_back(sd_rd_addr);
        if (exp_rd.size() == 0) unexpected("sd_read", sd_rd_addr);
        else check("sd_read_addr", sd_rd_addr, exp_rd.pop_front());
      end
    end
  end

  initial begin
    int base;
    int t;
    int low_strobes;
    reset     = 1'b1;
    rx_data   = 8'h00;
    rx_strobe = 1'b0;
    tx_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;

    // Burst read of four words
    exp_str("1234"); send("1234@");
    exp_str("4");    send("4l");
    for (int i = 0; i < 4; i++) exp_rd.push_back(AB'(32'h1234 + i));
    exp_str("10111213\r\n");
    send("r");
    wait_idle("burst4");
    check("burst4_addr_end", sd_rd_addr, 25'h1238);

    // Single write, with an unknown byte in the middle
    exp_str("20");  send("20@");
    exp_str("5a?"); send("5a ");
    exp_wr.push_back({25'h20, 8'h5a});
    exp_str("!");
    send("w");
    @(negedge clk);
    check("w_to_wr_enable_1cycle", sd_wr_enable, 1'b1);
    wait_idle("write");
    check("write_addr_end", sd_wr_addr, 25'h21);

    // Unknown byte, ignored CR, then '.' reads the next address
    exp_str("?"); send("z");
    send("\r");
    exp_rd.push_back(25'h22);
    exp_str("fe\r\n");
    send(".");
    wait_idle("dot");
    check("dot_addr_end", sd_rd_addr, 25'h23);

    // Zero length: no SDRAM traffic at all
    exp_str("0");    send("0l");
    exp_str("\r\n"); send("r");
    wait_idle("len0_read");
    exp_str("!");    send("f");
    wait_idle("len0_fill");

    // Fill 256 words under alternating busy
    busy_mode = 1;
    exp_str("0");   send("0@");
    exp_str("100"); send("100l");
    base = wr_seen;
    for (int i = 0; i < 256; i++) exp_wr.push_back({AB'(i), 8'(i)});
    exp_str("!");
    send("f");
    wait_idle("fill");
    busy_mode = 0;
    check("fill_write_count", wr_seen - base, 256);
    check("fill_addr_end", sd_wr_addr, 25'h100);

    // Address wrap inside a burst
    exp_str("1ffffff"); send("1ffffff@");
    exp_str("2");       send("2l");
    exp_rd.push_back(25'h1ffffff);
    exp_rd.push_back(25'h0);
    exp_str("dbdc\r\n");
    send("r");
    wait_idle("wrap");
    check("wrap_addr_end", sd_rd_addr, 25'h1);

    // Abort during the third read of a 0x40-word burst; other bytes ignored while busy
    exp_str("0");  send("0@");
    exp_str("40"); send("40l");
    for (int i = 0; i < 3; i++) exp_rd.push_back(AB'(i));
    exp_str("dcddde\r\n");
    base = rd_seen;
    send("r");
    wait_rd("abort_first", base + 1);
    send("5");
    wait_rd("abort_third", base + 3);
    send("q");
    wait_idle("abort");
    check("abort_read_count", rd_seen - base, 3);
    check("abort_addr_end", sd_rd_addr, 25'h3);

    // tx_ready held low for 50 cycles after the first hex character
    exp_str("10"); send("10@");
    exp_str("2");  send("2l");
    exp_rd.push_back(25'h10);
    exp_rd.push_back(25'h11);
    exp_str("eced\r\n");
    base = tx_seen;
    send("r");
    t = 0;
    while (tx_seen < base + 1 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("first_hex_char_in_time", (t < 500), 1'b1);
    #1 tx_ready = 1'b0;
    low_strobes = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_strobe) low_strobes++;
    end
    check("no_strobe_while_not_ready", low_strobes, 0);
    check("held_char_pending", active, 1'b1);
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_idle("tx_hold");

    // Reset while a read request is on the bus
    exp_str("0");  send("0@");
    exp_str("40"); send("40l");
    exp_rd.push_back(25'h0);
    exp_rd.push_back(25'h1);
    exp_str("dc");
    send("r");
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(sd_rd_enable && sd_rd_addr == 25'h1) && t < 500);
    check("second_read_in_time", (t < 500), 1'b1);
    #1 reset = 1'b1;
    #1 check_outputs_zero("reset_mid_burst");
    check("pre_reset_scoreboard_empty", exp_tx.size() + exp_rd.size() + exp_wr.size(), 0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;

    // After reset: addr=0 and len=1, so 'r' reads exactly one word at 0
    exp_rd.push_back(25'h0);
    exp_str("dc\r\n");
    send("r");
    wait_idle("post_reset");
    check("post_reset_addr_end", sd_rd_addr, 25'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_uart_monitor.md
Name: sdram_uart_monitor

Overview:
Parametrised UART command interpreter for SDRAM bring-up and debug. It replaces the ad-hoc single-byte peek logic with a general bridge. Its inputs are a byte stream from uart_rx and the sdram_controller logical interface. Supported operations are burst reads with hex output, single writes, pattern fill and abort. It sits between uart_rx / uart_tx_fifo and sdram_controller in test tops.

Parameters:
ADDR_BITS, 25, SDRAM logical address width
DATA_BITS, 8, SDRAM word width; multiple of 4, max 32
LEN_BITS, 16, burst-length register width
HEX_OUT, 1, 1 = each read word printed as DATA_BITS/4 lowercase hex chars; 0 = raw low byte printed

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_data  in  8  received byte from uart_rx
rx_strobe  in  1  one-cycle valid for rx_data
tx_data  out  8  byte to uart_tx_fifo
tx_strobe  out  1  one-cycle push to uart_tx_fifo
tx_ready  in  1  FIFO can accept a byte; tie 1 if unused
sd_wr_addr  out  ADDR_BITS  write address
sd_wr_data  out  DATA_BITS  write data
sd_wr_enable  out  1  one-cycle write request
sd_rd_addr  out  ADDR_BITS  read address
sd_rd_enable  out  1  one-cycle read request
sd_rd_data  in  DATA_BITS  read data
sd_rd_ready  in  1  one-cycle read-data valid
sd_busy  in  1  controller busy
active  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async, active-high): all outputs 0; acc=0, addr=0, len=1, FSM=IDLE.
- Registers: acc[max(ADDR_BITS,LEN_BITS,DATA_BITS)-1:0], addr[ADDR_BITS-1:0], len[LEN_BITS-1:0], remaining count, data word register.
- IDLE byte handling, one rx byte per cycle:
  - 0-9 / a-f / A-F: acc <= {acc<<4 | nibble}, upper bits drop off; echo the byte.
  - '@': addr <= acc; acc <= 0.
  - 'l': len <= acc[LEN_BITS-1:0]; acc <= 0.
  - 'x': addr <= 0; acc <= 0.
  - 'w': write acc[DATA_BITS-1:0] at addr; addr++; acc <= 0.
  - 'r': read len words from addr.
  - '.': addr++, then read 1 word; len unchanged.
  - 'f': fill len words from addr with data = addr[DATA_BITS-1:0].
  - '\r' / '\n': ignored.
  - any other byte: emit "?".
- FSM states: IDLE, RD_ISSUE, RD_WAIT, TX_WORD, WR_ISSUE, FILL_ISSUE, TX_EOL, TX_ACK.
- Request rule: sd_rd_enable or sd_wr_enable pulses exactly 1 cycle, only when sd_busy=0. The two are never high in the same cycle.
- Addresses: sd_rd_addr and sd_wr_addr are driven from addr and held stable while the request is pending.
- Read flow: RD_ISSUE -> RD_WAIT. On sd_rd_ready, capture sd_rd_data -> TX_WORD.
- TX_WORD:
  - HEX_OUT=1: emit MS nibble first.
  - HEX_OUT=0: emit the low byte.
  - Then addr++, remaining--.
  - remaining>0 -> RD_ISSUE; else -> TX_EOL ("\r\n") -> IDLE.
- Write flow: WR_ISSUE issues the write -> TX_ACK ("!") -> IDLE.
- Fill flow: FILL_ISSUE issues one write per non-busy cycle, addr++ each. When done -> TX_ACK ("!").
- TX gating: tx_strobe asserted only when tx_ready=1. Otherwise the FSM holds the current character with no loss. Echo and "?" are dropped if tx_ready=0 (echo is best-effort).
- len=0: 'r' emits only "\r\n"; 'f' emits only "!". No SDRAM access in either case.
- addr wraps modulo 2^ADDR_BITS, including mid-burst.
- rx while not IDLE: byte ignored, except 'q'.
  - 'q' aborts after any outstanding read completes (RD_WAIT still waits for sd_rd_ready), then emits "\r\n" -> IDLE.
  - addr keeps its advanced value.
- Reset mid-operation: immediate return to reset state; a pending request strobe is cleared asynchronously.
- active = (state != IDLE).
- Latency: 'w' byte to sd_wr_enable is 1 cycle when sd_busy=0.

Decomposition:
- Shared package/header: ASCII constants for command bytes, CR, LF, '!', '?'; FSM state encodings.
- One sub-module, hex_nibble: 4-bit value to ASCII lowercase hex, plus ASCII to {valid, nibble}.
- Everything else lives in sdram_uart_monitor.

Test Plan:
- Send "1234@", "4l", "r" with memory[0x1234..0x1237]=0x10,0x11,0x12,0x13 -> tx "1234" echo, then "10111213\r\n"; addr ends at 0x1238.
- Send "5a w" at addr 0x20 -> one sd_wr_enable, sd_wr_addr=0x20, sd_wr_data=0x5A; tx "5a" then "?" (for space) then "!"; addr=0x21.
- Send "0@", "100l", "f" with sd_busy toggling every other cycle -> exactly 256 writes, data = addr[7:0], never issued while busy; "!" follows.
- Send "1ffffff@", "2l", "r" -> reads at 0x1FFFFFF then 0x0000000 (wrap); addr ends at 1.
- During a 0x40-word read, send 'q' after 3 words -> current read completes, "\r\n" emitted, no further sd_rd_enable; other rx bytes are ignored.
- Hold tx_ready=0 for 50 cycles mid-hex-output -> no tx_strobe while low; output string intact afterwards; assert reset mid-burst -> all outputs 0 the same cycle.
